// File: rtl/mux_arb_8to1_32bit.sv
// Eight-requester arbiter sharing one 8-to-1 mux into a registered valid/ready output stage.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (ch0 highest) instead of round-robin.
module mux_arb_8to1_32bit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [8*DATA_WIDTH-1:0] i_data,
  input  logic [7:0]              i_valid,
  output logic [7:0]              o_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [2:0]              o_sel,
  output logic                    o_valid,
  input  logic                    i_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      grant;
  logic            found;
  logic            ld;
  logic            xfer;
  logic [2:0]      idx;
  logic [DATA_WIDTH-1:0] mux_data;

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign ptr = 3'd0;
`else
  logic [2:0] ptr_q;
  assign ptr = ptr_q;
`endif

  assign o_valid = (state == FULL);
  assign ld      = ~o_valid | i_ready;

  // First valid channel at or after the pointer, wrapping 7 -> 0.
  always_comb begin
    found = 1'b0;
    grant = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + i[2:0];
      if (!found && i_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign xfer = found & ld & i_rst_n;

  always_comb begin
    o_ready = 8'h00;
    if (xfer)
      o_ready[grant] = 1'b1;
  end

  // Only the granted slice feeds the register; other lanes never propagate.
  assign mux_data = i_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= EMPTY;
      o_data <= '0;
      o_sel  <= 3'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (xfer) begin
            state  <= FULL;
            o_data <= mux_data;
            o_sel  <= grant;
          end
        end
        FULL: begin
          if (xfer) begin
            o_data <= mux_data;
            o_sel  <= grant;
          end else if (i_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifndef MUX_ARB_FIXED_PRIO_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ptr_q <= 3'd0;
    else if (xfer)
      ptr_q <= grant + 3'd1;
  end
`endif

endmodule

// File: tb/tb_mux_arb_8to1_32bit.sv
// Randomized and directed bench for mux_arb_8to1_32bit.
// Reference model tracks the output slot and the scan start as plain integers.
module tb_mux_arb_8to1_32bit;
  localparam int DW = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [8*DW-1:0] i_data;
  logic [7:0]      i_valid;
  logic [7:0]      o_ready;
  logic [DW-1:0]   o_data;
  logic [2:0]      o_sel;
  logic            o_valid;
  logic            i_ready;

  int checks = 0;
  int failures = 0;

  int          mptr;
  bit          mvalid;
  logic [DW-1:0] mdata;
  int          msel;

  mux_arb_8to1_32bit #(.DATA_WIDTH(DW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    mptr   = 0;
    mvalid = 0;
    mdata  = '0;
    msel   = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 8'h00;
    i_ready = 1'b0;
    i_data  = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    i_data[k*DW +: DW] = v;
  endtask

  // Compare against the model, then advance one clock and update the model.
  task automatic do_cycle(input string tag);
    int g;
    bit found;
    bit ld;
    logic [7:0] exp_rdy;
    #1;
    found = 0;
    g = 0;
    for (int j = 0; j < 8; j++) begin
      int c;
      c = (mptr + j) % 8;
      if (!found && i_valid[c]) begin
        found = 1;
        g = c;
      end
    end
    ld = !mvalid || i_ready;
    exp_rdy = (found && ld) ? (8'h01 << g) : 8'h00;
    checks++;
    if (o_ready !== exp_rdy) begin
      failures++;
      $display("FAIL %s o_ready got=%h exp=%h", tag, o_ready, exp_rdy);
    end
    checks++;
    if (o_valid !== mvalid) begin
      failures++;
      $display("FAIL %s o_valid got=%b exp=%b", tag, o_valid, mvalid);
    end
    if (mvalid) begin
      checks++;
      if (o_data !== mdata || o_sel !== 3'(msel)) begin
        failures++;
        $display("FAIL %s o_data/o_sel got=%h/%0d exp=%h/%0d",
                 tag, o_data, o_sel, mdata, msel);
      end
    end
    @(posedge i_clk);
    if (found && ld) begin
      mvalid = 1;
      mdata  = i_data[g*DW +: DW];
      msel   = g;
`ifdef MUX_ARB_FIXED_PRIO_EN
      mptr   = 0;
`else
      mptr   = (g + 1) % 8;
`endif
    end else if (i_ready) begin
      mvalid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 8'hFF;
    i_ready = 1'b1;
    i_data  = '1;
    #2;
    checks++;
    if (o_ready !== 8'h00) begin
      failures++;
      $display("FAIL reset_ready got=%h exp=00", o_ready);
    end
    do_reset();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_sel !== 3'd0) begin
      failures++;
      $display("FAIL reset_out got v=%b d=%h s=%0d exp 0/0/0", o_valid, o_data, o_sel);
    end
    i_ready = 1'b1;
    repeat (2) do_cycle("idle");
  endtask

  task automatic test_alternate();
    int exp_seq[3];
    do_reset();
    set_ch(0, 32'hAAAA0000);
    set_ch(7, 32'h7777FFFF);
    i_valid = 8'h81;
    i_ready = 1'b1;
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0};
`else
    exp_seq = '{0, 7, 0};
`endif
    do_cycle("alt0");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_sel !== 3'(exp_seq[i]) ||
          o_data !== (exp_seq[i] == 0 ? 32'hAAAA0000 : 32'h7777FFFF)) begin
        failures++;
        $display("FAIL alt_seq%0d got=%0d/%h exp sel=%0d", i, o_sel, o_data, exp_seq[i]);
      end
      do_cycle("alt");
    end
  endtask

  task automatic test_all_valid();
    do_reset();
    for (int k = 0; k < 8; k++) set_ch(k, 32'hC0DE0000 + k);
    i_valid = 8'hFF;
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (!$onehot(o_ready)) begin
        failures++;
        $display("FAIL allv_onehot got=%h exp one bit", o_ready);
      end
      do_cycle("allv");
      checks++;
`ifdef MUX_ARB_FIXED_PRIO_EN
      if (o_sel !== 3'd0) begin
`else
      if (o_sel !== 3'(i % 8)) begin
`endif
        failures++;
        $display("FAIL allv_sel got=%0d step=%0d", o_sel, i);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_ch(0, 32'h12345678);
    set_ch(2, 32'h22222222);
    i_valid = 8'h01;
    i_ready = 1'b1;
    do_cycle("stall_ld");
    i_valid = 8'h04;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle("stall");
      checks++;
      if (o_data !== 32'h12345678 || o_sel !== 3'd0 || o_valid !== 1'b1 ||
          o_ready !== 8'h00) begin
        failures++;
        $display("FAIL stall_hold got d=%h s=%0d v=%b r=%h exp 12345678/0/1/00",
                 o_data, o_sel, o_valid, o_ready);
      end
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 8'h04) begin
      failures++;
      $display("FAIL stall_release got=%h exp=04", o_ready);
    end
    do_cycle("stall_rel");
    checks++;
    if (o_data !== 32'h22222222 || o_sel !== 3'd2) begin
      failures++;
      $display("FAIL stall_next got=%h/%0d exp 22222222/2", o_data, o_sel);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ch(5, 32'h55555555);
    i_valid = 8'h20;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_ready !== 8'h20) begin
        failures++;
        $display("FAIL wrap_grant got=%h exp=20", o_ready);
      end
      do_cycle("wrap");
    end
    checks++;
    if (o_sel !== 3'd5 || o_data !== 32'h55555555) begin
      failures++;
      $display("FAIL wrap_out got=%0d/%h exp 5/55555555", o_sel, o_data);
    end
    i_valid = 8'h00;
    do_cycle("wrap_drain");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 8; k++) set_ch(k, 32'hBEEF0000 + k);
    i_valid = 8'hFF;
    i_ready = 1'b1;
    repeat (3) do_cycle("burst");
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset o_valid got=%b exp=0", o_valid);
    end
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_valid = 8'h10;
    #1;
    checks++;
    if (o_ready !== 8'h10) begin
      failures++;
      $display("FAIL post_reset_grant got=%h exp=10", o_ready);
    end
    do_cycle("post_rst");
    checks++;
    if (o_sel !== 3'd4 || o_data !== 32'hBEEF0004) begin
      failures++;
      $display("FAIL post_reset_out got=%0d/%h exp 4/beef0004", o_sel, o_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) set_ch(k, $urandom);
      i_valid = 8'($urandom);
      if ($urandom_range(0, 3) == 0) i_valid = 8'h01 << $urandom_range(0, 7);
      i_ready = ($urandom_range(0, 3) != 0);
      do_cycle("rand");
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_all_valid();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
